// File: rtl/complex_row_reduce_sequencer_if.sv
// Bundle of command, chunk, datapath and result signals for the complex row-reduce sequencer.
// master: the sequencer; slave: the surrounding buffer, datapath and consumer.
interface complex_row_reduce_sequencer_if #(
    parameter int unsigned element_width = 64,
    parameter int unsigned no_of_units   = 8,
    parameter int unsigned cnt_width     = 4
);
    localparam int unsigned ROW_W = no_of_units * element_width;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [cnt_width-1:0]     cmd_chunks;
    logic                     chunk_valid;
    logic                     chunk_ready;
    logic [ROW_W-1:0]         chunk_data;
    logic [ROW_W-1:0]         row_data;
    logic                     row_start;
    logic                     outsider4;
    logic                     tree_done;
    logic                     acc_done;
    logic [element_width-1:0] acc_result;
    logic                     result_valid;
    logic                     result_ready;
    logic [element_width-1:0] result_data;
    logic                     result_err;
    logic                     busy;

    modport master (
        input  cmd_valid, cmd_chunks, chunk_valid, chunk_data,
               tree_done, acc_done, acc_result, result_ready,
        output cmd_ready, chunk_ready, row_data, row_start, outsider4,
               result_valid, result_data, result_err, busy
    );

    modport slave (
        output cmd_valid, cmd_chunks, chunk_valid, chunk_data,
               tree_done, acc_done, acc_result, result_ready,
        input  cmd_ready, chunk_ready, row_data, row_start, outsider4,
               result_valid, result_data, result_err, busy
    );
endinterface

// File: rtl/complex_row_reduce_sequencer.sv
// Sequences one row reduction: fetches N chunks, issues each to the adder tree,
// waits for the accumulated sum and returns it, aborting on a datapath stall.
module complex_row_reduce_sequencer #(
    parameter int unsigned element_width  = 64,
    parameter int unsigned no_of_units    = 8,
    parameter int unsigned cnt_width      = 4,
    parameter int unsigned timeout_cycles = 255
) (
    input logic clk,
    input logic main_reset_n,
    complex_row_reduce_sequencer_if.master bus
);
    localparam int unsigned ROW_W = no_of_units * element_width;
    localparam int unsigned WD_W  = $clog2(timeout_cycles + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_TREE, WAIT_ACC, RESULT
    } state_e;

    state_e                   state_q, state_d;
    logic [cnt_width-1:0]     count_q, count_d;
    logic [cnt_width-1:0]     issued_q, issued_d;
    logic [cnt_width-1:0]     done_q, done_d;
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic [ROW_W-1:0]         row_data_q, row_data_d;
    logic                     row_start_q, row_start_d;
    logic                     outsider4_q, outsider4_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     chunk_ready_q, chunk_ready_d;
    logic                     result_valid_q, result_valid_d;
    logic [element_width-1:0] result_data_q, result_data_d;
    logic                     result_err_q, result_err_d;
    logic                     busy_q, busy_d;
    logic                     wdog_expired;

    assign wdog_expired = (wdog_q == WD_W'(timeout_cycles));

    // Next state, counters and datapath-facing registers
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        issued_d      = issued_q;
        done_d        = done_q;
        wdog_d        = '0;
        row_data_d    = row_data_q;
        row_start_d   = row_start_q;
        outsider4_d   = 1'b0;
        result_data_d = result_data_q;
        result_err_d  = result_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    count_d  = bus.cmd_chunks;
                    issued_d = '0;
                    done_d   = '0;
                    if (bus.cmd_chunks == '0) begin
                        result_data_d = '0;
                        result_err_d  = 1'b0;
                        state_d       = RESULT;
                    end else begin
                        row_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.chunk_valid && chunk_ready_q) begin
                    row_data_d  = bus.chunk_data;
                    outsider4_d = 1'b1;
                    issued_d    = issued_q + 1'b1;
                    state_d     = WAIT_TREE;
                end
            end
            WAIT_TREE: begin
                wdog_d = wdog_q + 1'b1;
                // A completion in the expiry cycle takes priority over the abort
                if (bus.tree_done) begin
                    done_d = done_q + 1'b1;
                    wdog_d = '0;
                    state_d = (done_d == count_q) ? WAIT_ACC : ISSUE;
                end else if (wdog_expired) begin
                    result_data_d = '0;
                    result_err_d  = 1'b1;
                    state_d       = RESULT;
                end
            end
            WAIT_ACC: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.acc_done) begin
                    result_data_d = bus.acc_result;
                    result_err_d  = 1'b0;
                    state_d       = RESULT;
                end else if (wdog_expired) begin
                    result_data_d = '0;
                    result_err_d  = 1'b1;
                    state_d       = RESULT;
                end
            end
            RESULT: begin
                if (bus.result_ready && result_valid_q) begin
                    row_start_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d    = (state_d == IDLE);
        chunk_ready_d  = (state_d == ISSUE);
        result_valid_d = (state_d == RESULT);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            issued_q       <= '0;
            done_q         <= '0;
            wdog_q         <= '0;
            row_data_q     <= '0;
            row_start_q    <= 1'b0;
            outsider4_q    <= 1'b0;
            cmd_ready_q    <= 1'b0;
            chunk_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_err_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            issued_q       <= issued_d;
            done_q         <= done_d;
            wdog_q         <= wdog_d;
            row_data_q     <= row_data_d;
            row_start_q    <= row_start_d;
            outsider4_q    <= outsider4_d;
            cmd_ready_q    <= cmd_ready_d;
            chunk_ready_q  <= chunk_ready_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_err_q   <= result_err_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.chunk_ready  = chunk_ready_q;
    assign bus.row_data     = row_data_q;
    assign bus.row_start    = row_start_q;
    assign bus.outsider4    = outsider4_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_data_q;
    assign bus.result_err   = result_err_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_complex_row_reduce_sequencer.sv
// Self-checking bench for complex_row_reduce_sequencer: directed vector table, hand-written
// corner sequences and random jobs checked against a job-level latency/result model.
module tb_complex_row_reduce_sequencer;
    localparam int unsigned EW = 64;
    localparam int unsigned NU = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 255;
    localparam int unsigned RW = EW * NU;

    logic clk = 1'b0;
    logic main_reset_n;

    always #5 clk = ~clk;

    complex_row_reduce_sequencer_if #(.element_width(EW), .no_of_units(NU), .cnt_width(CW)) bus ();

    complex_row_reduce_sequencer #(
        .element_width(EW), .no_of_units(NU), .cnt_width(CW), .timeout_cycles(TO)
    ) dut (
        .clk(clk),
        .main_reset_n(main_reset_n),
        .bus(bus)
    );

    typedef struct {
        int          chunks;
        int          gap;
        int          tlat;
        int          alat;
        int          rr;
        bit          stall;
        bit          spur;
        logic [63:0] accv;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   gap_tbl[16];
    int   tlat_tbl[16];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Free-running observers of strobes, cmd_ready during a job, and unannounced row_data changes
    int         pulse_cnt = 0;
    int         ready_hi_cnt = 0;
    int         row_chg_cnt = 0;
    bit         in_job = 1'b0;
    logic [RW-1:0] row_prev = '0;

    always @(negedge clk) begin
        if (bus.outsider4 === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (in_job && bus.cmd_ready === 1'b1) ready_hi_cnt <= ready_hi_cnt + 1;
        if (main_reset_n === 1'b1 && bus.row_data !== row_prev && bus.outsider4 !== 1'b1)
            row_chg_cnt <= row_chg_cnt + 1;
        row_prev <= bus.row_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", n, a, e);
        end
    endtask

    task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", n, a, e);
        end
    endtask

    task automatic chkrow(input string n, input logic [RW-1:0] a, input logic [RW-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", n, a, e);
        end
    endtask

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(RW / 32); i++) r = {r[RW-33:0], 32'($urandom)};
        return r;
    endfunction

    // Acts as buffer, datapath and consumer for one job; gaps and tree latencies come from the tables
    task automatic run_job(input int chunks, input int alat, input int rr, input bit stall,
                           input bit spur, input logic [63:0] accv,
                           output int lat, output logic [63:0] rdata, output logic rerr);
        int p0, r0, w0, to, stable_bad;
        logic [RW-1:0] d;
        bit aborted;
        lat = 0; stable_bad = 0; aborted = 1'b0;
        p0 = pulse_cnt; r0 = ready_hi_cnt; w0 = row_chg_cnt;
        chk1("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_chunks = CW'(chunks);
        tick(); lat++;
        bus.cmd_valid = 1'b0;
        in_job = 1'b1;
        chk1("row_start_on_accept", bus.row_start, 1'(chunks != 0));
        chk1("chunk_ready_on_accept", bus.chunk_ready, 1'(chunks != 0));
        chk1("busy_on_accept", bus.busy, 1'b1);
        for (int c = 0; c < chunks && !aborted; c++) begin
            repeat (gap_tbl[c]) begin tick(); lat++; end
            d = rnd_row();
            bus.chunk_valid = 1'b1;
            bus.chunk_data = d;
            tick(); lat++;
            bus.chunk_valid = 1'b0;
            bus.chunk_data = rnd_row();
            chkrow("row_data_new", bus.row_data, d);
            chk1("chunk_ready_after_take", bus.chunk_ready, 1'b0);
            if (stall) begin
                to = 0;
                while (bus.result_valid !== 1'b1 && to < 400) begin tick(); lat++; to++; end
                aborted = 1'b1;
            end else begin
                for (int t = 0; t < tlat_tbl[c]; t++) begin
                    if (spur && t == 0) begin
                        bus.acc_done = 1'b1;
                        bus.acc_result = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                    tick(); lat++;
                    bus.acc_done = 1'b0;
                end
                bus.tree_done = 1'b1;
                tick(); lat++;
                bus.tree_done = 1'b0;
            end
        end
        if (chunks != 0 && !stall) begin
            repeat (alat) begin tick(); lat++; end
            bus.acc_done = 1'b1;
            bus.acc_result = accv;
            tick(); lat++;
            bus.acc_done = 1'b0;
            bus.acc_result = {$urandom, $urandom};
        end
        chki("outsider4_pulses", pulse_cnt - p0, stall ? 1 : chunks);
        chk1("result_valid", bus.result_valid, 1'b1);
        rdata = bus.result_data;
        rerr = bus.result_err;
        for (int r = 0; r < rr; r++) begin
            if (spur && r == 0) bus.tree_done = 1'b1;
            tick();
            bus.tree_done = 1'b0;
            if (bus.result_valid !== 1'b1 || bus.result_data !== rdata || bus.result_err !== rerr)
                stable_bad++;
        end
        chki("result_stable", stable_bad, 0);
        chk1("row_start_in_result", bus.row_start, 1'(chunks != 0));
        in_job = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        chk1("result_valid_after_hs", bus.result_valid, 1'b0);
        chk1("row_start_after_hs", bus.row_start, 1'b0);
        chk1("cmd_ready_after_hs", bus.cmd_ready, 1'b1);
        chk1("busy_after_hs", bus.busy, 1'b0);
        chki("cmd_ready_low_in_job", ready_hi_cnt - r0, 0);
        chki("row_data_hold", row_chg_cnt - w0, 0);
    endtask

    initial begin
        vec_t          v;
        int            lat, exp_lat, c;
        logic [63:0]   rd, accv;
        logic          rerr;
        logic [RW-1:0] d;

        bus.cmd_valid = 1'b0; bus.cmd_chunks = '0; bus.chunk_valid = 1'b0; bus.chunk_data = '0;
        bus.tree_done = 1'b0; bus.acc_done = 1'b0; bus.acc_result = '0; bus.result_ready = 1'b0;
        main_reset_n = 1'b0;

        //          chunks gap tlat alat rr stall  spur   accv                   exp_data               err   lat
        vecs[0] = '{1,  0, 3, 2, 0, 1'b0, 1'b0, 64'h0000_0005_0000_0003, 64'h0000_0005_0000_0003, 1'b0, 9};
        vecs[1] = '{0,  0, 0, 0, 2, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 64'h0,                   1'b0, 1};
        vecs[2] = '{2,  0, 0, 0, 1, 1'b0, 1'b0, 64'hA5A5_0000_5A5A_FFFF, 64'hA5A5_0000_5A5A_FFFF, 1'b0, 6};
        vecs[3] = '{15, 0, 0, 0, 0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 32};
        vecs[4] = '{3,  0, 0, 0, 0, 1'b1, 1'b0, 64'h7777_7777_7777_7777, 64'h0,                   1'b1, 258};
        vecs[5] = '{2,  1, 1, 1, 2, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0001, 1'b0, 11};
        vecs[6] = '{3,  0, 2, 1, 1, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 15};

        repeat (2) tick();
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("rst_chunk_ready", bus.chunk_ready, 1'b0);
        chk1("rst_row_start", bus.row_start, 1'b0);
        chk1("rst_result_valid", bus.result_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        main_reset_n = 1'b1;
        tick();
        chk1("cmd_ready_after_release", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            for (int k = 0; k < 16; k++) begin gap_tbl[k] = v.gap; tlat_tbl[k] = v.tlat; end
            run_job(v.chunks, v.alat, v.rr, v.stall, v.spur, v.accv, lat, rd, rerr);
            chki($sformatf("vec%0d_latency", i), lat, v.exp_lat);
            chk64($sformatf("vec%0d_result_data", i), rd, v.exp_data);
            chk1($sformatf("vec%0d_result_err", i), rerr, v.exp_err);
        end

        // Four chunks with uneven upstream gaps and a slow consumer
        gap_tbl[0] = 0; gap_tbl[1] = 2; gap_tbl[2] = 5; gap_tbl[3] = 0;
        tlat_tbl[0] = 1; tlat_tbl[1] = 0; tlat_tbl[2] = 2; tlat_tbl[3] = 1;
        run_job(4, 1, 3, 1'b0, 1'b0, 64'h0BAD_CAFE_1234_0042, lat, rd, rerr);
        chki("four_chunk_latency", lat, 22);
        chk64("four_chunk_data", rd, 64'h0BAD_CAFE_1234_0042);
        chk1("four_chunk_err", rerr, 1'b0);

        // Reset pulsed while the first chunk of a 3-chunk job is in the tree
        bus.cmd_valid = 1'b1; bus.cmd_chunks = CW'(3);
        tick();
        bus.cmd_valid = 1'b0;
        d = rnd_row();
        bus.chunk_valid = 1'b1; bus.chunk_data = d;
        tick();
        bus.chunk_valid = 1'b0;
        chk1("mid_outsider4", bus.outsider4, 1'b1);
        #2 main_reset_n = 1'b0;
        #1;
        chk1("arst_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("arst_chunk_ready", bus.chunk_ready, 1'b0);
        chkrow("arst_row_data", bus.row_data, '0);
        chk1("arst_row_start", bus.row_start, 1'b0);
        chk1("arst_outsider4", bus.outsider4, 1'b0);
        chk1("arst_result_valid", bus.result_valid, 1'b0);
        chk64("arst_result_data", bus.result_data, 64'h0);
        chk1("arst_result_err", bus.result_err, 1'b0);
        chk1("arst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1 main_reset_n = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin gap_tbl[k] = 0; tlat_tbl[k] = 0; end
        run_job(2, 0, 0, 1'b0, 1'b0, 64'h0000_00AB_0000_00CD, lat, rd, rerr);
        chki("post_reset_latency", lat, 6);
        chk64("post_reset_data", rd, 64'h0000_00AB_0000_00CD);
        chk1("post_reset_err", rerr, 1'b0);

        // Random jobs against the job-level model
        for (int j = 0; j < 30; j++) begin
            c = int'($urandom_range(0, 6));
            exp_lat = 1;
            for (int k = 0; k < 16; k++) begin
                gap_tbl[k] = int'($urandom_range(0, 3));
                tlat_tbl[k] = int'($urandom_range(0, 3));
                if (k < c) exp_lat += gap_tbl[k] + tlat_tbl[k] + 2;
            end
            v.alat = int'($urandom_range(0, 3));
            if (c != 0) exp_lat += v.alat + 1;
            accv = {$urandom, $urandom};
            run_job(c, v.alat, int'($urandom_range(0, 2)), 1'b0, 1'(j % 3 == 0), accv, lat, rd, rerr);
            chki($sformatf("rand%0d_latency", j), lat, exp_lat);
            chk64($sformatf("rand%0d_data", j), rd, (c == 0) ? 64'h0 : accv);
            chk1($sformatf("rand%0d_err", j), rerr, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1, "bench time limit reached");
    end
endmodule
